// File: rtl/exe_stage_pkg.sv
// ---------------------------------------------------------------------------
// arm_exe_pkg
// Shared definitions for the ARM execute stage: ALU opcodes, shifter types,
// the multiplier FSM state encoding and the bit positions of the NZCV flags
// inside the status register.
// No ports (package).
// ---------------------------------------------------------------------------
package arm_exe_pkg;

    // ALU opcodes carried on exe_cmd
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_MUL = 4'b1010;

    // Register-form shift types, shift_operand[6:5]
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Iterative multiplier states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Positions inside status = {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_if.sv
// ---------------------------------------------------------------------------
// exe_stage_if
// Bundles the execute stage's pipeline-facing signals.
//   *_in signals : values from the ID/EXE pipeline register
//   remaining    : results towards EXE/MEM, branch info, status and stall
// modport master : the upstream/downstream pipeline side (drives *_in)
// modport slave  : the execute stage itself
// ---------------------------------------------------------------------------
interface exe_stage_if;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic        b_in;
    logic        s_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in;
    logic [31:0] val_rn_in;
    logic [31:0] val_rm_in;
    logic        imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;

    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [3:0]  dest;
    logic [31:0] st_val;
    logic [31:0] alu_result;
    logic [31:0] branch_addr;
    logic        branch_taken;
    logic [3:0]  status;
    logic        stall;

    modport master (
        output wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
               pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
               signed_imm_24_in, dest_in,
        input  wb_en, mem_r_en, mem_w_en, dest, st_val, alu_result,
               branch_addr, branch_taken, status, stall
    );

    modport slave (
        input  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
               pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
               signed_imm_24_in, dest_in,
        output wb_en, mem_r_en, mem_w_en, dest, st_val, alu_result,
               branch_addr, branch_taken, status, stall
    );
endinterface

// File: rtl/exe_stage_val2_gen.sv
// ---------------------------------------------------------------------------
// val2_gen
// Combinational second-operand generator.
//   imm           : rotated 8-bit immediate form
//   mem_en        : load/store offset form (12-bit zero-extended)
//   val_rm        : register operand for the shifter form
//   shift_operand : 12-bit shifter operand field
//   val2          : selected second ALU operand
// ---------------------------------------------------------------------------
module val2_gen
    import arm_exe_pkg::*;
(
    input  logic        imm,
    input  logic        mem_en,
    input  logic [31:0] val_rm,
    input  logic [11:0] shift_operand,
    output logic [31:0] val2
);

    logic [31:0] imm_ext_s;
    logic [4:0]  rot_amt_s;
    logic [4:0]  sh_amt_s;

    // Rotate right; a shift by 32 yields 0 so amount 0 passes through intact
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        ror32 = (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    assign imm_ext_s = {24'd0, shift_operand[7:0]};
    assign rot_amt_s = {shift_operand[11:8], 1'b0};
    assign sh_amt_s  = shift_operand[11:7];

    // Select immediate, memory offset, or shifted register operand
    always_comb begin
        val2 = val_rm;
        if (imm) begin
            val2 = ror32(imm_ext_s, rot_amt_s);
        end else if (mem_en) begin
            val2 = {20'd0, shift_operand};
        end else begin
            case (shift_operand[6:5])
                SH_LSL:  val2 = val_rm << sh_amt_s;
                SH_LSR:  val2 = val_rm >> sh_amt_s;
                SH_ASR:  val2 = $unsigned($signed(val_rm) >>> sh_amt_s);
                SH_ROR:  val2 = ror32(val_rm, sh_amt_s);
                default: val2 = val_rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
// Execute stage of the 5-stage ARM pipeline: Val2 generation, ALU, branch
// target adder, NZCV status register and an iterative shift-add multiplier
// that stalls the upstream stages while it runs.
//   clk   : pipeline clock
//   rst   : synchronous active-high reset
//   flush : aborts a running multiply and suppresses this cycle's flag update
//   bus   : ID/EXE inputs and EXE/MEM outputs (exe_stage_if.slave)
// ---------------------------------------------------------------------------
module exe_stage
    import arm_exe_pkg::*;
#(
    parameter int MUL_ITERS = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    exe_stage_if.slave bus
);

    localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

    mul_state_e       state_r, state_nxt_s;
    logic [31:0]      mcand_r, mcand_nxt_s;
    logic [31:0]      mplier_r, mplier_nxt_s;
    logic [31:0]      prod_r, prod_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [3:0]       status_r, status_nxt_s;

    logic [31:0] val2_s;
    logic [31:0] alu_res_s;
    logic [32:0] sum_s;
    logic        alu_c_s;
    logic        alu_v_s;
    logic        is_mul_s;
    logic        fsm_stall_s;
    logic        stall_s;
    logic [31:0] branch_off_s;

    val2_gen u_val2_gen (
        .imm           (bus.imm_in),
        .mem_en        (bus.mem_r_en_in | bus.mem_w_en_in),
        .val_rm        (bus.val_rm_in),
        .shift_operand (bus.shift_operand_in),
        .val2          (val2_s)
    );

    assign is_mul_s = (bus.exe_cmd_in == EXE_MUL);

    // Single-cycle ALU; C and V default to their held values
    always_comb begin
        alu_res_s = 32'd0;
        sum_s     = 33'd0;
        alu_c_s   = status_r[FLAG_C];
        alu_v_s   = status_r[FLAG_V];
        case (bus.exe_cmd_in)
            EXE_MOV: alu_res_s = val2_s;
            EXE_MVN: alu_res_s = ~val2_s;
            EXE_ADD, EXE_ADC: begin
                sum_s = {1'b0, bus.val_rn_in} + {1'b0, val2_s};
                if (bus.exe_cmd_in == EXE_ADC) begin
                    sum_s = sum_s + {32'd0, status_r[FLAG_C]};
                end else begin
                    sum_s = sum_s;
                end
                alu_res_s = sum_s[31:0];
                alu_c_s   = sum_s[32];
                alu_v_s   = (bus.val_rn_in[31] == val2_s[31]) &&
                            (sum_s[31] != bus.val_rn_in[31]);
            end
            EXE_SUB, EXE_SBC: begin
                sum_s = {1'b0, bus.val_rn_in} - {1'b0, val2_s};
                if (bus.exe_cmd_in == EXE_SBC) begin
                    sum_s = sum_s - {32'd0, ~status_r[FLAG_C]};
                end else begin
                    sum_s = sum_s;
                end
                alu_res_s = sum_s[31:0];
                // ARM carry on subtract is the inverse of borrow
                alu_c_s   = ~sum_s[32];
                alu_v_s   = (bus.val_rn_in[31] != val2_s[31]) &&
                            (sum_s[31] != bus.val_rn_in[31]);
            end
            EXE_AND: alu_res_s = bus.val_rn_in & val2_s;
            EXE_ORR: alu_res_s = bus.val_rn_in | val2_s;
            EXE_EOR: alu_res_s = bus.val_rn_in ^ val2_s;
            default: alu_res_s = 32'd0;   // includes MUL, produced by the FSM
        endcase
    end

    // Multiplier FSM next-state, datapath and stall request
    always_comb begin
        state_nxt_s  = state_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        prod_nxt_s   = prod_r;
        cnt_nxt_s    = cnt_r;
        fsm_stall_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (is_mul_s && !flush) begin
                    fsm_stall_s  = 1'b1;
                    state_nxt_s  = ST_BUSY;
                    mcand_nxt_s  = bus.val_rn_in;
                    mplier_nxt_s = bus.val_rm_in;
                    prod_nxt_s   = 32'd0;
                    cnt_nxt_s    = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                fsm_stall_s = 1'b1;
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    if (mplier_r[0]) begin
                        prod_nxt_s = prod_r + mcand_r;
                    end else begin
                        prod_nxt_s = prod_r;
                    end
                    mcand_nxt_s  = mcand_r << 1;
                    mplier_nxt_s = mplier_r >> 1;
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
            end
            // Upstream advances at this edge, so never restart from DONE
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Status register next value: ALU flags in IDLE, N/Z only from a finished multiply
    always_comb begin
        status_nxt_s = status_r;
        if (bus.s_in && !flush) begin
            if (state_r == ST_IDLE && !is_mul_s) begin
                status_nxt_s = {alu_res_s[31], (alu_res_s == 32'd0), alu_c_s, alu_v_s};
            end else if (state_r == ST_DONE) begin
                status_nxt_s[FLAG_N] = prod_r[31];
                status_nxt_s[FLAG_Z] = (prod_r == 32'd0);
            end else begin
                status_nxt_s = status_r;
            end
        end else begin
            status_nxt_s = status_r;
        end
    end

    // State and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
            prod_r   <= 32'd0;
            cnt_r    <= '0;
            status_r <= 4'b0000;
        end else begin
            state_r  <= state_nxt_s;
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_nxt_s;
            prod_r   <= prod_nxt_s;
            cnt_r    <= cnt_nxt_s;
            status_r <= status_nxt_s;
        end
    end

    assign stall_s      = fsm_stall_s & ~rst;
    assign branch_off_s = {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};

    assign bus.stall        = stall_s;
    assign bus.wb_en        = bus.wb_en_in    & ~stall_s;
    assign bus.mem_r_en     = bus.mem_r_en_in & ~stall_s;
    assign bus.mem_w_en     = bus.mem_w_en_in & ~stall_s;
    assign bus.dest         = bus.dest_in;
    assign bus.st_val       = bus.val_rm_in;
    assign bus.alu_result   = (state_r == ST_DONE) ? prod_r : alu_res_s;
    assign bus.branch_addr  = bus.pc_in + branch_off_s;
    assign bus.branch_taken = bus.b_in;
    assign bus.status       = status_r;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage ARM pipeline. It sits directly downstream of the ID/EXE pipeline register and consumes that register's outputs. It contains the Val2 generator, the ALU, the branch-target adder, the architectural NZCV status register, and an iterative 32-cycle multiplier. The multiplier asserts stall so that upstream registers freeze while it runs.

Parameters:
MUL_ITERS, 32, number of shift-add iterations per multiply (one per multiplier bit)

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  aborts an in-flight multiply; suppresses the status update this cycle
wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control bits from the ID/EXE register
exe_cmd_in  in  4  ALU opcode
pc_in  in  32  pc+4 of the instruction
val_rn_in, val_rm_in  in  32 each  register operands
imm_in  in  1  selects the rotated-immediate form of Val2
shift_operand_in  in  12  shifter operand field
signed_imm_24_in  in  24  branch offset
dest_in  in  4  destination register
wb_en, mem_r_en, mem_w_en  out  1 each  control passed to EXE/MEM; forced 0 while stall=1
dest  out  4  passthrough of dest_in
st_val  out  32  store data; passthrough of val_rm_in
alu_result  out  32  ALU or multiply result
branch_addr  out  32  pc_in + (sign_ext(signed_imm_24_in) << 2), mod 2^32
branch_taken  out  1  equals b_in
status  out  4  NZCV register, {N,Z,C,V}; feeds the ID stage sr input
stall  out  1  multiplier busy; holds the IF, IF/ID and ID/EXE registers

Behaviour:
- Reset (rst=1 at a rising edge): status=4'b0000, FSM=IDLE, counter=0, product/multiplicand/multiplier regs=0.
- During reset, outputs are combinational from the inputs with stall=0.
- Val2 selection:
  - If imm_in: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Else if mem_r_en_in|mem_w_en_in: {20'b0, so[11:0]}.
  - Else: val_rm_in shifted by so[11:7] using type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes val_rm_in through unchanged.
- ALU opcodes (exe_cmd):
  - 0001 MOV, 1001 MVN(~Val2)
  - 0010 ADD, 0011 ADC(+C)
  - 0100 SUB, 0101 SBC(rn-Val2-!C)
  - 0110 AND, 0111 ORR, 1000 EOR
  - 1010 MUL(rn*rm, low 32 bits)
  - any other opcode: result 0.
- ALU flags:
  - Arithmetic ops compute on 33 bits.
  - C = bit 32 for adds; for subtracts C = NOT borrow.
  - V = signed overflow.
  - Logical ops and MOV/MVN leave C and V unchanged.
  - N = result[31]; Z = (result==0).
- Status update: the register loads new flags at the rising edge when s_in=1, flush=0, and the ALU (not the MUL FSM) produced the result.
- MUL flags: N and Z load at the DONE edge if s_in=1; C and V are unchanged.
- Single-cycle ops: alu_result is combinational, zero added latency, stall=0.
- MUL FSM:
  - IDLE: if exe_cmd_in==1010 and flush=0, then stall=1, load mcand=val_rn_in, mplier=val_rm_in, prod=0, cnt=0, go to BUSY.
  - BUSY: stall=1. Each cycle: if mplier[0], prod+=mcand; then mcand<<=1, mplier>>=1, cnt++. When cnt==MUL_ITERS-1, go to DONE.
  - DONE: stall=0, alu_result=prod, wb_en follows wb_en_in. Unconditionally go to IDLE; the upstream register advances at this same edge, so there is no restart.
  - Stall is high for exactly 1+MUL_ITERS cycles (33 by default); the result is presented on cycle 34.
  - flush=1 in BUSY or DONE: go to IDLE next edge, stall=0 from that edge, and no status update.
  - rst in any state: IDLE next edge.
  - An operand of 0 still takes the full iteration count; there is no early exit.
- Simultaneous s_in=1 and flush=1: flush wins, status is held.
- Branch: branch_taken=b_in, independent of flags. Condition evaluation happens in ID.

Decomposition:
- Package arm_exe_pkg:
  - exe_cmd constants (EXE_MOV, EXE_MVN, ..., EXE_MUL)
  - shift-type constants (SH_LSL, SH_LSR, SH_ASR, SH_ROR)
  - MUL FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- Sub-module val2_gen: purely combinational Val2 selection and shifter, instantiated once. The ALU, status register and MUL FSM stay in exe_stage.

Test Plan:
- ADD overflow: exe_cmd=0010, val_rn=0x7FFFFFFF, imm=1, so=0x001, s=1 -> alu_result=0x80000000; status=4'b1001 after the edge.
- Rotated immediate MOV: imm=1, so=0x4FF, exe_cmd=0001 -> alu_result=0xFF000000; with s=0, status is unchanged.
- SBC with borrow: status C=0, val_rn=5, Val2=5 (register form, so=0) -> result 0xFFFFFFFF, NZCV=1000.
- Branch: pc_in=0x00000100, signed_imm_24=0xFFFFFE, b=1 -> branch_addr=0x000000F8, branch_taken=1.
- MUL: val_rn=7, val_rm=6, s=1 -> stall=1 for 33 cycles, wb_en=0 throughout; on cycle 34 alu_result=42, stall=0, Z=0, N=0, C/V unchanged.
- MUL abort: assert rst at BUSY cycle 10 -> stall=0 next cycle, status=0. Repeat with flush at cycle 10 instead of rst -> stall=0 next cycle, status held.
